hub_div_operand_classifier: RTL and testbench



---
 rtl/hub_div_operand_classifier_if.sv | 29 ++
 rtl/hub_div_operand_classifier.sv | 134 +++++++++++++
 tb/tb_hub_div_operand_classifier.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/hub_div_operand_classifier_if.sv
// Operand/result bus of the FPHUB divider input stage.
// slave = classifier side, master = upstream producer plus downstream consumer.
interface hub_div_operand_classifier_if #(
   parameter int E = 8,
   parameter int M = 23,
   parameter int C = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [E+M:0]     X_in;
   logic [E+M:0]     Y_in;
   logic             out_valid;
   logic             out_ready;
   logic [E+M:0]     X;
   logic [E+M:0]     Y;
   logic [C-1:0]     X_special_case;
   logic [C-1:0]     Y_special_case;
   logic             any_special;

   modport slave (
      input  in_valid, X_in, Y_in, out_ready,
      output in_ready, out_valid, X, Y, X_special_case, Y_special_case, any_special
   );

   modport master (
      output in_valid, X_in, Y_in, out_ready,
      input  in_ready, out_valid, X, Y, X_special_case, Y_special_case, any_special
   );
endinterface

// File: rtl/hub_div_operand_classifier.sv
// FPHUB divider input stage: classifies X/Y into special-case codes and buffers
// them in a two-entry skid buffer. Define HUB_DIV_ONE_DETECT_EN to enable +-1 codes.
module hub_div_class_unit #(
   parameter int E = 8,
   parameter int M = 23,
   parameter int C = 3
) (
   input  logic [E+M:0] op,
   output logic [C-1:0] code
);
`ifdef HUB_DIV_ONE_DETECT_EN
   localparam bit ONE_EN = 1'b1;
`else
   localparam bit ONE_EN = 1'b0;
`endif
   localparam logic [E-1:0] ONE_EXP = {1'b1, {(E-1){1'b0}}};

   logic         sign;
   logic [E-1:0] expo;
   logic [M-1:0] man;

   assign sign = op[E+M];
   assign expo = op[E+M-1:M];
   assign man  = op[M-1:0];

   // No NaN in HUB: all-ones exponent is infinity whatever the mantissa.
   always_comb begin
      code = '0;
      if (&expo)
         code = sign ? C'(2) : C'(1);
      else if (~|expo)
         code = sign ? C'(4) : C'(3);
      else if (ONE_EN && (expo == ONE_EXP) && ~|man)
         code = sign ? C'(6) : C'(5);
   end
endmodule

module hub_div_operand_classifier #(
   parameter int M            = 23,
   parameter int E            = 8,
   parameter int special_case = 7
) (
   input  logic clk,
   input  logic rst_n,
   hub_div_operand_classifier_if.slave bus
);
   localparam int W = E + M + 1;
   localparam int C = $clog2(special_case);

   typedef struct packed {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [C-1:0] xc;
      logic [C-1:0] yc;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   logic [1:0][W-1:0] ops;
   logic [1:0][C-1:0] codes;
   entry_t            in_e, o_q, s_q;
   state_t            state_q, state_d;
   logic              in_ready_q;
   logic              accept, drain;
   logic              load_o_in, load_o_s, load_s;

   assign ops = {bus.Y_in, bus.X_in};

   for (genvar g = 0; g < 2; g++) begin : g_cls
      hub_div_class_unit #(.E(E), .M(M), .C(C)) u_cls (
         .op   (ops[g]),
         .code (codes[g])
      );
   end

   assign in_e   = '{x: bus.X_in, y: bus.Y_in, xc: codes[0], yc: codes[1]};
   assign accept = bus.in_valid & in_ready_q;
   assign drain  = (state_q != EMPTY) & bus.out_ready;

   always_comb begin
      state_d   = state_q;
      load_o_in = 1'b0;
      load_o_s  = 1'b0;
      load_s    = 1'b0;
      case (state_q)
         EMPTY: if (accept) begin
            state_d   = ONE;
            load_o_in = 1'b1;
         end
         ONE: begin
            if (accept && drain) begin
               load_o_in = 1'b1;
            end else if (accept) begin
               state_d = FULL;
               load_s  = 1'b1;
            end else if (drain) begin
               state_d = EMPTY;
            end
         end
         FULL: if (drain) begin
            state_d  = ONE;
            load_o_s = 1'b1;
         end
         default: state_d = EMPTY;
      endcase
   end

   // in_ready comes straight from a flop so out_ready never reaches upstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
         o_q        <= '0;
         s_q        <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != FULL);
         if (load_o_in)
            o_q <= in_e;
         else if (load_o_s)
            o_q <= s_q;
         if (load_s)
            s_q <= in_e;
      end
   end

   assign bus.in_ready       = in_ready_q;
   assign bus.out_valid      = (state_q != EMPTY);
   assign bus.X              = o_q.x;
   assign bus.Y              = o_q.y;
   assign bus.X_special_case = o_q.xc;
   assign bus.Y_special_case = o_q.yc;
   assign bus.any_special    = (|o_q.xc) | (|o_q.yc);
endmodule

// File: tb/tb_hub_div_operand_classifier.sv
// Bench for hub_div_operand_classifier: directed cases plus random traffic
// checked against a queue-based reference of the two-entry buffer.
module tb_hub_div_operand_classifier;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   logic [63:0] q[$];

`ifdef HUB_DIV_ONE_DETECT_EN
   localparam bit ONE_EN = 1'b1;
`else
   localparam bit ONE_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   hub_div_operand_classifier_if #(.E(8), .M(23), .C(3)) bus ();

   hub_div_operand_classifier #(.M(23), .E(8), .special_case(7)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   function automatic int ref_code(input logic [31:0] v);
      int s  = int'(v[31]);
      int ex = int'(v[30:23]);
      int mn = int'(v[22:0]);
      if (ex == 255) return (s != 0) ? 2 : 1;
      if (ex == 0)   return (s != 0) ? 4 : 3;
      if (ONE_EN && ex == 128 && mn == 0) return (s != 0) ? 6 : 5;
      return 0;
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] r = $urandom;
      case ($urandom_range(0, 7))
         0: return r | 32'h7F80_0000;
         1: return r & 32'h807F_FFFF;
         2: return {r[31], 31'h4000_0000};
         3: return {r[31], 31'h4000_0001};
         4: return {r[31], 31'h3F80_0000};
         default: return r;
      endcase
   endfunction

   task automatic check_outputs();
      logic [63:0] e;
      int xc, yc;
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
         e  = q[0];
         xc = ref_code(e[63:32]);
         yc = ref_code(e[31:0]);
         chk("X", 64'(bus.X), 64'(e[63:32]));
         chk("Y", 64'(bus.Y), 64'(e[31:0]));
         chk("X_code", 64'(bus.X_special_case), 64'(xc));
         chk("Y_code", 64'(bus.Y_special_case), 64'(yc));
         chk("any_special", 64'(bus.any_special), 64'((xc != 0) || (yc != 0)));
      end
   endtask

   // One clock: check at negedge, then update the reference at posedge.
   task automatic tick();
      bit acc, drn;
      @(negedge clk);
      check_outputs();
      acc = bus.in_valid && (q.size() < 2);
      drn = bus.out_ready && (q.size() > 0);
      @(posedge clk);
      if (drn) void'(q.pop_front());
      if (acc) q.push_back({bus.X_in, bus.Y_in});
      #1;
   endtask

   task automatic send(input logic [31:0] x, input logic [31:0] y);
      bus.in_valid  = 1'b1;
      bus.X_in      = x;
      bus.Y_in      = y;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a, b;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.X_in      = '0;
      bus.Y_in      = '0;
      bus.out_ready = 1'b0;
      #12;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_X", 64'(bus.X), 64'd0);
      chk("rst_any", 64'(bus.any_special), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      send(32'h3F80_0000, 32'h4000_0000);
      chk("lat_valid", 64'(bus.out_valid), 64'd1);
      chk("lat_xc", 64'(bus.X_special_case), 64'd0);
      chk("lat_yc", 64'(bus.Y_special_case), ONE_EN ? 64'd5 : 64'd0);
      chk("lat_any", 64'(bus.any_special), ONE_EN ? 64'd1 : 64'd0);
      send(32'h7FFF_FFFF, 32'h8000_0000);
      chk("inf_p", 64'(bus.X_special_case), 64'd1);
      chk("zero_n", 64'(bus.Y_special_case), 64'd4);
      chk("any_inf", 64'(bus.any_special), 64'd1);
      send(32'hFF80_0000, 32'h3F80_0000);
      chk("inf_n", 64'(bus.X_special_case), 64'd2);
      send(32'h4000_0000, 32'hC000_0000);
      chk("one_p", 64'(bus.X_special_case), ONE_EN ? 64'd5 : 64'd0);
      chk("one_n", 64'(bus.Y_special_case), ONE_EN ? 64'd6 : 64'd0);
      tick();

      // Backpressure: A into O, B into S, C refused.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      a = 32'h1111_1111; b = 32'h2222_2222;
      bus.X_in = a; bus.Y_in = ~a; tick();
      bus.X_in = b; bus.Y_in = ~b; tick();
      chk("full_in_ready", 64'(bus.in_ready), 64'd0);
      bus.X_in = 32'h3333_3333; bus.Y_in = 32'h4444_4444; tick();
      chk("full_hold_X", 64'(bus.X), 64'(a));
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("drain_order", 64'(bus.X), 64'(b));
      tick();
      chk("drain_empty", 64'(bus.out_valid), 64'd0);

      // Streaming at full rate.
      bus.in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.X_in = rand_op(); bus.Y_in = rand_op();
         tick();
         chk("stream_valid", 64'(bus.out_valid), 64'd1);
         chk("stream_ready", 64'(bus.in_ready), 64'd1);
      end
      bus.in_valid = 1'b0;
      tick();

      // Reset while FULL.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.X_in = 32'h4040_0000; bus.Y_in = 32'h0000_0001; tick();
      bus.X_in = 32'h7F80_0000; bus.Y_in = 32'h4000_0000; tick();
      chk("pre_rst_full", 64'(bus.in_ready), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
      chk("mid_rst_X", 64'(bus.X), 64'd0);
      q.delete();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         bus.X_in      = rand_op();
         bus.Y_in      = rand_op();
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
